// File: rtl/sub_32_pipe.sv
// ============================================================================
//  Module      : sub_32_pipe
//  Description : Two-stage pipelined 32-bit subtractor, d = a - b - b_in.
//                Stage 1 computes the low 16 bits and their borrow. Stage 2
//                computes the high 16 bits from that borrow. Both stages use
//                valid/ready handshakes with full-throughput backpressure.
//                Define SUB32_FLAGS_EN to generate the ovf and zero flags.
//                In the default build ovf and zero are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_32_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        b_out,
    output logic        ovf,
    output logic        zero
);

    localparam int unsigned c_HALF = 16;

    // ------------------------------------------------------------------
    // Stage 1 state
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [c_HALF-1:0] r_s1_dlo;
    logic              r_s1_borrow;
    logic [c_HALF-1:0] r_s1_a_hi;   // bit 15 is the minuend sign bit
    logic [c_HALF-1:0] r_s1_b_hi;   // bit 15 is the subtrahend sign bit

    // ------------------------------------------------------------------
    // Stage 2 state
    // ------------------------------------------------------------------
    logic        r_s2_valid;
    logic [31:0] r_d;
    logic        r_b_out;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic w_s2_free;     // stage 2 is empty or its result leaves this edge
    logic w_s2_load;     // stage 2 captures stage 1 this edge
    logic w_s1_take;     // stage 1 may capture new operands this edge
    logic w_accept;      // an operand set is accepted this edge

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s2_load = r_s1_valid && w_s2_free;
    // Stage 1 is free when it is empty or its content moves to stage 2.
    // This does not depend on in_valid.
    assign w_s1_take = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && w_s1_take;
    assign in_ready  = w_s1_take;

    // ------------------------------------------------------------------
    // Arithmetic. The 17-bit subtractions return the borrow in bit 16.
    // ------------------------------------------------------------------
    logic [c_HALF:0] w_lo;
    logic [c_HALF:0] w_hi;

    assign w_lo = {1'b0, a[c_HALF-1:0]} - {1'b0, b[c_HALF-1:0]} - {{c_HALF{1'b0}}, b_in};
    assign w_hi = {1'b0, r_s1_a_hi} - {1'b0, r_s1_b_hi} - {{c_HALF{1'b0}}, r_s1_borrow};

    // Stage 1 valid bit. It is refilled or drained whenever the slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_take) begin
            r_s1_valid <= in_valid;
        end
    end

    // Stage 1 data. It captures the low half and the raw high operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_dlo    <= '0;
            r_s1_borrow <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_b_hi   <= '0;
        end else if (w_accept) begin
            r_s1_dlo    <= w_lo[c_HALF-1:0];
            r_s1_borrow <= w_lo[c_HALF];
            r_s1_a_hi   <= a[31:c_HALF];
            r_s1_b_hi   <= b[31:c_HALF];
        end
    end

    // Stage 2 valid bit. While the output is stalled, it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    // Stage 2 result. The high half combines with the registered low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d     <= '0;
            r_b_out <= 1'b0;
        end else if (w_s2_load) begin
            r_d     <= {w_hi[c_HALF-1:0], r_s1_dlo};
            r_b_out <= w_hi[c_HALF];
        end
    end

    assign out_valid = r_s2_valid;
    assign d         = r_d;
    assign b_out     = r_b_out;

`ifdef SUB32_FLAGS_EN
    // ------------------------------------------------------------------
    // Flags. The low-half zero test is registered in stage 1.
    // The high-half test and overflow are resolved in stage 2.
    // ------------------------------------------------------------------
    logic r_s1_lo_zero;
    logic r_ovf;
    logic r_zero;
    logic w_ovf;
    logic w_zero;

    // Overflow: operand signs differ and the result sign differs from a.
    assign w_ovf  = (r_s1_a_hi[c_HALF-1] != r_s1_b_hi[c_HALF-1]) &&
                    (w_hi[c_HALF-1] != r_s1_a_hi[c_HALF-1]);
    assign w_zero = r_s1_lo_zero && (w_hi[c_HALF-1:0] == '0);

    // Stage 1 low-half zero flag. It travels with the operand set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_lo_zero <= 1'b0;
        end else if (w_accept) begin
            r_s1_lo_zero <= (w_lo[c_HALF-1:0] == '0);
        end
    end

    // Stage 2 flag registers. They load in step with d and b_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_s2_load) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub_32_pipe.sv
// ============================================================================
//  Module      : tb_sub_32_pipe
//  Description : Scoreboard testbench for sub_32_pipe. Directed vectors carry
//                hand-computed results. A monitor checks each consumed result
//                against the queue and checks that stalled outputs hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_32_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        b_out;
    logic        ovf;
    logic        zero;

    int n_cmp;
    int n_err;

    vec_t vecs[14];
    vec_t exp_q[$];

    sub_32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vbin,
                                input logic [31:0] vd, input logic vbout, input logic vovf,
                                input logic vzero);
        vec_t v;
        v.a = va; v.b = vb; v.bin = vbin; v.d = vd; v.bout = vbout;
`ifdef SUB32_FLAGS_EN
        v.ovf = vovf; v.zero = vzero;
`else
        v.ovf = 1'b0; v.zero = 1'b0;
`endif
        return v;
    endfunction

    // Drive one operand set from a negedge. Retry until in_ready is seen, then push the expectation.
    task automatic send(input vec_t v);
        int tries;
        tries = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = v.a; b = v.b; b_in = v.bin;
        #1;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 after %0d cycles", tries);
        end else begin
            exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: checks consumed results in order and checks that stalled outputs hold.
    logic        stalled;
    logic [34:0] held;
    initial begin
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (out_valid) begin
                if (stalled)
                    chk("hold_stable", {29'd0, d[2:0]} ^ 32'(held[31:0] != d) , {29'd0, held[2:0]});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_result: got d=%h with empty scoreboard", d);
                    end else begin
                        vec_t e;
                        e = exp_q.pop_front();
                        chk("d", d, e.d);
                        chk("b_out", {31'd0, b_out}, {31'd0, e.bout});
                        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                        chk("zero", {31'd0, zero}, {31'd0, e.zero});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {ovf, zero, b_out, d};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; b_in = 1'b0;

        vecs[0]  = mk(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(32'h0001_0000, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        vecs[10] = mk(32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(32'h0000_0020, 32'h0000_0002, 1'b0, 32'h0000_001E, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(32'h0000_0030, 32'h0000_0003, 1'b0, 32'h0000_002D, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(32'h0000_0040, 32'h0000_0004, 1'b1, 32'h0000_003B, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_flags", {29'd0, b_out, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(vecs[i]);
        drain();

        // Backpressure: out_ready low for 3 cycles while streaming 4 sets
        fork
            begin
                for (int i = 10; i < 14; i++) send(vecs[i]);
            end
            begin
                @(negedge clk);
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #1;
                chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[4]);
        @(negedge clk);
        #1;
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_d", d, 32'd0);
        chk("midrst_flags", {29'd0, b_out, ovf, zero}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

        // First accept right after reset release
        send(vecs[5]);
        drain();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
